// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arb_pkg
//  Description : Shared types and encodings for the SRAM port arbiter.
//                - arb_state_t : arbiter sequencing states
//                - PORT_*      : requester identifiers (grant_owner encoding)
//                - OP_*        : latched operation type
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic PORT_IF  = 1'b0;
    localparam logic PORT_MEM = 1'b1;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_port_arbiter
//  Description : Shares one SRAM controller port between the instruction
//                fetch path (read-only) and the memory-stage path
//                (read/write). One request is latched at a time, the
//                controller enable/ready handshake is sequenced, read data
//                is captured and a single-cycle ready pulse is returned to
//                the winning requester. Contention is resolved round-robin
//                and a watchdog bounds the time spent waiting on the
//                controller.
//
//  Ports:
//    clk, reset                 - clock, synchronous active-high reset
//    if_r_en/if_address         - fetch read request and address
//    if_rdata/if_ready          - fetch read data and completion pulse
//    mem_r_en/mem_w_en          - memory-stage read / write request
//    mem_address/mem_wdata      - memory-stage address and write data
//    mem_rdata/mem_ready        - memory-stage read data and completion pulse
//    sram_r_en/sram_w_en        - enables to the SRAM controller
//    sram_address/sram_wdata    - address / write data to the controller
//    sram_rdata/sram_ready      - read data / done from the controller
//    grant_owner                - owner of current/last transaction (1=mem)
//    timeout_err                - sticky watchdog-abort flag
//
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                TIMEOUT_CYC = 1023,
    parameter logic [DATA_W-1:0] ERR_DATA    = DATA_W'(32'hDEAD_BEEF)
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_r_en,
    input  logic [ADDR_W-1:0] if_address,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,

    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,

    output logic              sram_r_en,
    output logic              sram_w_en,
    output logic [ADDR_W-1:0] sram_address,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    input  logic              sram_ready,

    output logic              grant_owner,
    output logic              timeout_err
);

    // The wait counter only has to reach TIMEOUT_CYC-1.
    localparam int               CNT_W       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] c_wait_last = CNT_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);
    localparam logic             c_wdog_en   = (TIMEOUT_CYC != 0);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    arb_state_t        r_state;
    arb_state_t        w_next_state;

    logic              r_owner;
    logic              r_last_grant;
    logic              r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_mem_rdata;
    logic              r_timeout_err;

    // ------------------------------------------------------------------------
    // Request decode and round-robin selection
    // ------------------------------------------------------------------------
    logic              w_if_req;
    logic              w_mem_req;
    logic              w_grant_any;
    logic              w_grant_port;
    logic              w_wdog_fire;
    logic              w_cap_en;
    logic [DATA_W-1:0] w_cap_data;
    logic              w_active;

    always_comb begin
        w_if_req    = if_r_en;
        w_mem_req   = mem_r_en | mem_w_en;
        w_grant_any = w_if_req | w_mem_req;

        // On contention the port that did not win last time goes next, so
        // continuous contention alternates strictly between the two.
        if (w_if_req && w_mem_req) begin
            w_grant_port = ~r_last_grant;
        end else if (w_mem_req) begin
            w_grant_port = PORT_MEM;
        end else begin
            w_grant_port = PORT_IF;
        end
    end

    // Watchdog fires on the last permitted WAIT cycle if the controller has
    // still not answered; a late ready in that same cycle wins.
    always_comb begin
        w_wdog_fire = c_wdog_en && (r_state == WAIT) && !sram_ready &&
                      (r_wait_cnt == c_wait_last);

        // Aborted transactions return ERR_DATA to the owner even for writes,
        // so the requester can see the abort in its data as well as the flag.
        w_cap_en   = (r_state == WAIT) &&
                     ((sram_ready && (r_op == OP_READ)) || w_wdog_fire);
        w_cap_data = w_wdog_fire ? ERR_DATA : sram_rdata;
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_any) begin
                    w_next_state = ISSUE;
                end
            end
            // The controller may still report idle-ready while the enable is
            // first presented, so sram_ready is not looked at in ISSUE.
            ISSUE: begin
                w_next_state = WAIT;
            end
            WAIT: begin
                if (sram_ready || w_wdog_fire) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: request latch, wait counter, read-data capture
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner       <= PORT_MEM;
            r_last_grant  <= PORT_MEM;
            r_op          <= OP_READ;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wait_cnt    <= '0;
            r_if_rdata    <= '0;
            r_mem_rdata   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_any) begin
                        r_owner <= w_grant_port;
                        r_addr  <= (w_grant_port == PORT_MEM) ? mem_address : if_address;
                        r_wdata <= mem_wdata;
                        // Simultaneous read and write from the memory stage
                        // is resolved as a write.
                        r_op    <= ((w_grant_port == PORT_MEM) && mem_w_en) ? OP_WRITE : OP_READ;
                    end
                end
                WAIT: begin
                    r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    if (w_wdog_fire) begin
                        r_timeout_err <= 1'b1;
                    end
                    if (w_cap_en) begin
                        if (r_owner == PORT_MEM) begin
                            r_mem_rdata <= w_cap_data;
                        end else begin
                            r_if_rdata <= w_cap_data;
                        end
                    end
                end
                RESP: begin
                    r_last_grant <= r_owner;
                    r_wait_cnt   <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_active     = (r_state == ISSUE) || (r_state == WAIT);

        sram_r_en    = w_active && (r_op == OP_READ);
        sram_w_en    = w_active && (r_op == OP_WRITE);
        sram_address = w_active ? r_addr : '0;
        sram_wdata   = (w_active && (r_op == OP_WRITE)) ? r_wdata : '0;

        if_ready     = (r_state == RESP) && (r_owner == PORT_IF);
        mem_ready    = (r_state == RESP) && (r_owner == PORT_MEM);
        if_rdata     = r_if_rdata;
        mem_rdata    = r_mem_rdata;

        grant_owner  = r_owner;
        timeout_err  = r_timeout_err;
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_port_arbiter
//  Description : Self-checking bench for sram_port_arbiter. Directed vector
//                table, hand-written multi-cycle sequences (long write,
//                contention order, watchdog abort) and a randomized phase
//                checked against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_port_arbiter;

    localparam logic [31:0] c_err_data = 32'hDEAD_BEEF;
    localparam logic        H = 1'b1;
    localparam logic        L = 1'b0;

    logic        clk;
    logic        reset;
    logic        if_r_en;
    logic [31:0] if_address;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        sram_r_en;
    logic        sram_w_en;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        sram_ready;
    logic        grant_owner;
    logic        timeout_err;

    sram_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (8),
        .ERR_DATA    (c_err_data)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .if_r_en      (if_r_en),
        .if_address   (if_address),
        .if_rdata     (if_rdata),
        .if_ready     (if_ready),
        .mem_r_en     (mem_r_en),
        .mem_w_en     (mem_w_en),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .sram_r_en    (sram_r_en),
        .sram_w_en    (sram_w_en),
        .sram_address (sram_address),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .sram_ready   (sram_ready),
        .grant_owner  (grant_owner),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "time limit");
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        if_r_en    = 1'b0;
        mem_r_en   = 1'b0;
        mem_w_en   = 1'b0;
        sram_ready = 1'b0;
        sram_rdata = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Directed vector table: inputs for one edge, outputs expected after it
    // ------------------------------------------------------------------------
    typedef struct {
        logic        rst, ifr, mr, mw, rdy;
        logic [31:0] rdata;
        logic        e_ifrdy, e_memrdy, e_ren, e_wen, e_own, e_to;
        logic [31:0] e_addr, e_wdata, e_ifrd, e_memrd;
    } vec_t;

    vec_t tbl[13];

    // ------------------------------------------------------------------------
    // Handshake helper for the hand-written sequences: the controller answers
    // on the delay-th WAIT cycle (delay 0 = never answers).
    // ------------------------------------------------------------------------
    int          en_cycles;
    int          r_cycles;
    int          unstable;
    logic [31:0] first_addr;
    logic [31:0] first_wdata;
    logic        pulse_q[$];
    logic [31:0] pulse_rd[$];

    task automatic hs_run(input int delay, input int n_pulses, input int max_cyc, input logic [31:0] rd_val);
        int cnt;
        cnt = 0;
        en_cycles = 0;
        r_cycles  = 0;
        unstable  = 0;
        pulse_q.delete();
        pulse_rd.delete();
        sram_ready = 1'b0;
        for (int k = 0; k < max_cyc && pulse_q.size() < n_pulses; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (sram_r_en || sram_w_en) begin
                cnt++;
                en_cycles++;
                if (sram_r_en) r_cycles++;
                if (cnt == 1) begin
                    first_addr  = sram_address;
                    first_wdata = sram_wdata;
                end else if (sram_address !== first_addr || sram_wdata !== first_wdata) begin
                    unstable++;
                end
            end else begin
                cnt = 0;
            end
            if (if_ready) begin
                pulse_q.push_back(1'b0);
                pulse_rd.push_back(if_rdata);
            end
            if (mem_ready) begin
                pulse_q.push_back(1'b1);
                pulse_rd.push_back(mem_rdata);
            end
            sram_ready = (delay != 0) && (cnt == delay + 1);
            sram_rdata = rd_val;
        end
    endtask

    // ------------------------------------------------------------------------
    // Transaction-level reference model for the random phase
    // ------------------------------------------------------------------------
    logic        m_busy, m_owner, m_op_w, m_to, m_last, m_err;
    int          m_grant, m_resp, m_delay;
    logic [31:0] m_addr, m_wdata, m_data, m_if_rd, m_mem_rd;
    logic        rq_if, rq_mr, rq_mw;
    int          en_cnt;

    task automatic run_random(input int n_cyc);
        logic was_busy, resp_now, exp_en, en_obs, hit, own;
        int   op;
        m_busy = 0; m_owner = 1; m_last = 1; m_err = 0; m_to = 0;
        m_if_rd = '0; m_mem_rd = '0; m_delay = 1; m_grant = 0; m_resp = 0;
        rq_if = 0; rq_mr = 0; rq_mw = 0; en_cnt = 0;
        for (int i = 0; i < n_cyc; i++) begin
            was_busy = m_busy;
            resp_now = m_busy && (i == m_resp);
            if (resp_now) begin
                if (m_to) begin
                    m_err = 1'b1;
                    if (m_owner) m_mem_rd = c_err_data; else m_if_rd = c_err_data;
                end else if (!m_op_w) begin
                    if (m_owner) m_mem_rd = m_data; else m_if_rd = m_data;
                end
            end
            exp_en = m_busy && (i > m_grant) && (i < m_resp);

            chk1($sformatf("rnd%0d if_ready", i),  if_ready,    resp_now && !m_owner);
            chk1($sformatf("rnd%0d mem_ready", i), mem_ready,   resp_now && m_owner);
            chk ($sformatf("rnd%0d if_rdata", i),  if_rdata,    m_if_rd);
            chk ($sformatf("rnd%0d mem_rdata", i), mem_rdata,   m_mem_rd);
            chk1($sformatf("rnd%0d sram_r_en", i), sram_r_en,   exp_en && !m_op_w);
            chk1($sformatf("rnd%0d sram_w_en", i), sram_w_en,   exp_en && m_op_w);
            chk ($sformatf("rnd%0d sram_addr", i), sram_address, exp_en ? m_addr : 32'h0);
            chk ($sformatf("rnd%0d sram_wdata", i), sram_wdata, (exp_en && m_op_w) ? m_wdata : 32'h0);
            chk1($sformatf("rnd%0d grant_owner", i), grant_owner, m_owner);
            chk1($sformatf("rnd%0d timeout_err", i), timeout_err, m_err);

            if (resp_now) begin
                m_busy = 1'b0;
                m_last = m_owner;
                if (m_owner) begin
                    op = $urandom_range(3);
                    rq_mr = (op == 1) || (op == 3);
                    rq_mw = (op == 2) || (op == 3);
                end else begin
                    rq_if = ($urandom_range(1) == 1);
                end
            end

            // Requesters hold until served; the one in flight may let go early.
            if (!(m_busy && m_owner == 1'b0)) begin
                if (!rq_if && $urandom_range(2) == 0) rq_if = 1'b1;
            end else if (rq_if && $urandom_range(7) == 0) begin
                rq_if = 1'b0;
            end
            if (!(m_busy && m_owner == 1'b1)) begin
                if (!rq_mr && !rq_mw && $urandom_range(2) == 0) begin
                    op = $urandom_range(2);
                    rq_mr = (op != 1);
                    rq_mw = (op != 0);
                end
            end else if ((rq_mr || rq_mw) && $urandom_range(7) == 0) begin
                rq_mr = 1'b0;
                rq_mw = 1'b0;
            end

            if_r_en     = rq_if;
            mem_r_en    = rq_mr;
            mem_w_en    = rq_mw;
            if_address  = $urandom;
            mem_address = $urandom;
            mem_wdata   = $urandom;

            if (!was_busy && (rq_if || rq_mr || rq_mw)) begin
                own      = (rq_if && (rq_mr || rq_mw)) ? !m_last : (rq_mr || rq_mw);
                m_busy   = 1'b1;
                m_owner  = own;
                m_grant  = i;
                m_op_w   = own && rq_mw;
                m_addr   = own ? mem_address : if_address;
                m_wdata  = mem_wdata;
                m_data   = $urandom;
                if (!m_op_w && $urandom_range(9) == 0) begin
                    m_to   = 1'b1;
                    m_resp = i + 2 + 8;
                end else begin
                    m_to    = 1'b0;
                    m_delay = 1 + $urandom_range(3);
                    m_resp  = i + 2 + m_delay;
                end
            end

            // Controller: idle-ready when not enabled, also ready on the ISSUE
            // cycle (must be ignored), then answers after the chosen delay.
            en_obs     = sram_r_en | sram_w_en;
            en_cnt     = en_obs ? en_cnt + 1 : 0;
            hit        = en_obs && !m_to && (en_cnt == m_delay + 1);
            sram_ready = en_obs ? ((en_cnt == 1) || hit) : 1'b1;
            sram_rdata = hit ? m_data : $urandom;

            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    logic [31:0] prev_mem_rd;

    initial begin
        //            rst ifr mr mw rdy rdata          ifrdy memrdy ren wen own to  addr        wdata          ifrd           memrd
        tbl[0]  = '{H, L, L, L, L, 32'h0,          L, L, L, L, H, L, 32'h0,      32'h0,         32'h0,         32'h0};
        tbl[1]  = '{L, H, L, L, H, 32'h0,          L, L, H, L, L, L, 32'h100,    32'h0,         32'h0,         32'h0};
        tbl[2]  = '{L, H, L, L, H, 32'h0BAD_0BAD,  L, L, H, L, L, L, 32'h100,    32'h0,         32'h0,         32'h0};
        tbl[3]  = '{L, H, L, L, H, 32'h1234_5678,  H, L, L, L, L, L, 32'h0,      32'h0,         32'h1234_5678, 32'h0};
        tbl[4]  = '{L, L, L, L, H, 32'h0,          L, L, L, L, L, L, 32'h0,      32'h0,         32'h1234_5678, 32'h0};
        tbl[5]  = '{L, L, H, H, H, 32'h0,          L, L, L, H, H, L, 32'h40,     32'hCAFE_F00D, 32'h1234_5678, 32'h0};
        tbl[6]  = '{L, L, H, H, L, 32'h0,          L, L, L, H, H, L, 32'h40,     32'hCAFE_F00D, 32'h1234_5678, 32'h0};
        tbl[7]  = '{L, L, H, H, H, 32'h5555_AAAA,  L, H, L, L, H, L, 32'h0,      32'h0,         32'h1234_5678, 32'h0};
        tbl[8]  = '{L, L, L, L, H, 32'h0,          L, L, L, L, H, L, 32'h0,      32'h0,         32'h1234_5678, 32'h0};
        tbl[9]  = '{L, H, L, L, H, 32'h0,          L, L, H, L, L, L, 32'h100,    32'h0,         32'h1234_5678, 32'h0};
        tbl[10] = '{L, H, L, L, L, 32'h0,          L, L, H, L, L, L, 32'h100,    32'h0,         32'h1234_5678, 32'h0};
        tbl[11] = '{H, H, L, L, H, 32'h1234_5678,  L, L, L, L, H, L, 32'h0,      32'h0,         32'h0,         32'h0};
        tbl[12] = '{L, L, L, L, H, 32'h0,          L, L, L, L, H, L, 32'h0,      32'h0,         32'h0,         32'h0};

        reset = 1'b1; if_r_en = 0; mem_r_en = 0; mem_w_en = 0; sram_ready = 0;
        if_address = '0; mem_address = '0; mem_wdata = '0; sram_rdata = '0;
        @(negedge clk);

        for (int k = 0; k < 13; k++) begin
            reset       = tbl[k].rst;
            if_r_en     = tbl[k].ifr;
            mem_r_en    = tbl[k].mr;
            mem_w_en    = tbl[k].mw;
            sram_ready  = tbl[k].rdy;
            sram_rdata  = tbl[k].rdata;
            if_address  = 32'h0000_0100;
            mem_address = 32'h0000_0040;
            mem_wdata   = 32'hCAFE_F00D;
            @(posedge clk);
            @(negedge clk);
            chk1($sformatf("tbl%0d if_ready", k),    if_ready,     tbl[k].e_ifrdy);
            chk1($sformatf("tbl%0d mem_ready", k),   mem_ready,    tbl[k].e_memrdy);
            chk1($sformatf("tbl%0d sram_r_en", k),   sram_r_en,    tbl[k].e_ren);
            chk1($sformatf("tbl%0d sram_w_en", k),   sram_w_en,    tbl[k].e_wen);
            chk1($sformatf("tbl%0d grant_owner", k), grant_owner,  tbl[k].e_own);
            chk1($sformatf("tbl%0d timeout_err", k), timeout_err,  tbl[k].e_to);
            chk ($sformatf("tbl%0d sram_addr", k),   sram_address, tbl[k].e_addr);
            chk ($sformatf("tbl%0d sram_wdata", k),  sram_wdata,   tbl[k].e_wdata);
            chk ($sformatf("tbl%0d if_rdata", k),    if_rdata,     tbl[k].e_ifrd);
            chk ($sformatf("tbl%0d mem_rdata", k),   mem_rdata,    tbl[k].e_memrd);
        end

        // Memory-stage read to give mem_rdata a known value, then a write with
        // a six-cycle controller delay that must leave it untouched.
        do_reset();
        mem_r_en = 1'b1; mem_address = 32'h80;
        hs_run(1, 1, 20, 32'h0F0F_1234);
        mem_r_en = 1'b0;
        chk("memrd pulses", pulse_q.size(), 1);
        chk("memrd data", pulse_rd.size() > 0 ? pulse_rd[0] : 32'hx, 32'h0F0F_1234);
        prev_mem_rd = 32'h0F0F_1234;
        @(posedge clk); @(negedge clk);

        mem_w_en = 1'b1; mem_address = 32'h40; mem_wdata = 32'hCAFE_F00D;
        hs_run(6, 1, 40, 32'h9999_9999);
        mem_w_en = 1'b0;
        chk("wr w_en cycles", en_cycles, 7);
        chk("wr r_en cycles", r_cycles, 0);
        chk("wr unstable", unstable, 0);
        chk("wr addr", first_addr, 32'h40);
        chk("wr wdata", first_wdata, 32'hCAFE_F00D);
        chk("wr pulses", pulse_q.size(), 1);
        chk1("wr pulse owner", pulse_q.size() > 0 ? pulse_q[0] : 1'bx, 1'b1);
        chk("wr mem_rdata", mem_rdata, prev_mem_rd);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); @(negedge clk);
            chk1($sformatf("wr extra mem_ready %0d", k), mem_ready, 1'b0);
        end

        // Continuous contention from reset: fetch first, then alternate.
        do_reset();
        if_r_en = 1'b1; mem_r_en = 1'b1; if_address = 32'h300; mem_address = 32'h400;
        hs_run(1, 4, 40, 32'h1111_2222);
        if_r_en = 1'b0; mem_r_en = 1'b0;
        chk("rr pulses", pulse_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk1($sformatf("rr order %0d", k), pulse_q.size() > k ? pulse_q[k] : 1'bx, (k % 2) == 1);
        end

        // Controller never answers: abort after eight WAIT cycles.
        do_reset();
        if_r_en = 1'b1; if_address = 32'h200;
        hs_run(0, 1, 30, 32'h0);
        chk("to en cycles", en_cycles, 9);
        chk("to pulses", pulse_q.size(), 1);
        chk1("to pulse owner", pulse_q.size() > 0 ? pulse_q[0] : 1'bx, 1'b0);
        chk("to rdata", pulse_rd.size() > 0 ? pulse_rd[0] : 32'hx, c_err_data);
        chk1("to flag in resp", timeout_err, 1'b1);
        chk1("to r_en in resp", sram_r_en, 1'b0);
        if_r_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); @(negedge clk);
        end
        chk1("to flag sticky", timeout_err, 1'b1);
        if_r_en = 1'b1;
        hs_run(1, 1, 20, 32'hABCD_0001);
        if_r_en = 1'b0;
        chk("to next rdata", pulse_rd.size() > 0 ? pulse_rd[0] : 32'hx, 32'hABCD_0001);
        chk1("to flag after ok txn", timeout_err, 1'b1);
        do_reset();
        chk1("to flag after reset", timeout_err, 1'b0);

        run_random(600);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
